// File: rtl/hsv_pkg.sv
// Shared defaults, ID-width helper and the divider tag type for hsv_div_arbiter.
// The tag carries a divzero bit only when HSV_DIV_ARB_DIVZERO_EN is defined.
package hsv_pkg;

  localparam int unsigned NReqDef   = 3;
  localparam int unsigned WDef      = 12;
  localparam int unsigned DivLatDef = 4;
  // Fixed id field wide enough for any practical requester count.
  localparam int unsigned TagIdW    = 8;

  typedef logic [TagIdW-1:0] tag_id_t;

  typedef struct packed {
    logic    valid;
    tag_id_t id;
`ifdef HSV_DIV_ARB_DIVZERO_EN
    logic    divzero;
`endif
  } tag_t;

  function automatic int unsigned id_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/hsv_div_arbiter_if.sv
// Requester, divider and response signals of hsv_div_arbiter.
// slave: the arbiter itself; master: requesters, divider core and response consumer.
interface hsv_div_arbiter_if
  import hsv_pkg::*;
#(
  parameter int unsigned NREQ = NReqDef,
  parameter int unsigned W    = WDef,
  parameter int unsigned IdW  = id_w(NREQ)
) ();

  logic              ce;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic [W-1:0]      div_dividend;
  logic [W-1:0]      div_divisor;
  logic [W-1:0]      div_quotient;
  logic [W-1:0]      div_fractional;
  logic              resp_valid;
  logic [IdW-1:0]    resp_id;
  logic [W-1:0]      resp_quotient;
  logic [W-1:0]      resp_fractional;
  logic              resp_divzero;
  logic              busy;

  modport slave (
    input  ce, req_valid, req_dividend, req_divisor, div_quotient, div_fractional,
    output req_ready, div_dividend, div_divisor, resp_valid, resp_id, resp_quotient,
           resp_fractional, resp_divzero, busy
  );

  modport master (
    output ce, req_valid, req_dividend, req_divisor, div_quotient, div_fractional,
    input  req_ready, div_dividend, div_divisor, resp_valid, resp_id, resp_quotient,
           resp_fractional, resp_divzero, busy
  );

endinterface

// File: rtl/hsv_div_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer moves on grant.
module rr_arbiter
  import hsv_pkg::*;
#(
  parameter int unsigned NREQ = NReqDef,
  parameter int unsigned IdW  = id_w(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdW-1:0]  gnt_id_o
);

  logic [IdW-1:0] last_q, last_d;

  always_comb begin
    logic [IdW-1:0] idx;
    logic           found;
    gnt_o    = '0;
    gnt_id_o = '0;
    last_d   = last_q;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IdW'((32'(last_q) + k) % NREQ);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        last_d     = idx;
      end
    end
  end

  // Reset to the last requester so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= IdW'(NREQ - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/hsv_div_arbiter.sv
// Round-robin front end sharing one external fixed-latency divider; latency DIV_LAT+2.
// Define HSV_DIV_ARB_DIVZERO_EN to flag zero divisors and force their results to 0.
module hsv_div_arbiter
  import hsv_pkg::*;
#(
  parameter int unsigned NREQ    = NReqDef,
  parameter int unsigned W       = WDef,
  parameter int unsigned DIV_LAT = DivLatDef
) (
  input logic              clk,
  input logic              rst_n,
  hsv_div_arbiter_if.slave bus
);

  localparam int unsigned IdW = id_w(NREQ);

  logic [NREQ-1:0] gnt;
  logic [IdW-1:0]  gnt_id;
  logic            xfer;
  logic [W-1:0]    sel_a, sel_b;
  tag_t            tag_in, tag_out, op_tag_q;
  tag_t            pipe_q [DIV_LAT];
  logic [W-1:0]    div_a_q, div_b_q, quo_q, frac_q;
  logic            resp_valid_q;
  logic [IdW-1:0]  resp_id_q;
  logic            busy_c;
  logic            unused_tag_id;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (bus.ce & rst_n),
    .req_i    (bus.req_valid),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign xfer = |gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = bus.req_dividend[i*W +: W];
        sel_b = bus.req_divisor[i*W +: W];
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = xfer;
    tag_in.id    = tag_id_t'(gnt_id);
`ifdef HSV_DIV_ARB_DIVZERO_EN
    tag_in.divzero = xfer && (sel_b == '0);
`endif
  end

  assign tag_out       = pipe_q[DIV_LAT-1];
  assign unused_tag_id = ^tag_out.id;

  // Tag pipe never stalls: the divider core has no hold input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a_q  <= '0;
      div_b_q  <= '0;
      op_tag_q <= '0;
      for (int unsigned i = 0; i < DIV_LAT; i++) pipe_q[i] <= '0;
    end else begin
      if (xfer) begin
        div_a_q <= sel_a;
        div_b_q <= sel_b;
      end
      op_tag_q  <= tag_in;
      pipe_q[0] <= op_tag_q;
      for (int unsigned i = 1; i < DIV_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef HSV_DIV_ARB_DIVZERO_EN
  logic dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      quo_q        <= '0;
      frac_q       <= '0;
      dz_q         <= 1'b0;
    end else begin
      resp_valid_q <= tag_out.valid;
      if (tag_out.valid) begin
        resp_id_q <= tag_out.id[IdW-1:0];
        dz_q      <= tag_out.divzero;
        quo_q     <= tag_out.divzero ? '0 : bus.div_quotient;
        frac_q    <= tag_out.divzero ? '0 : bus.div_fractional;
      end
    end
  end

  assign bus.resp_divzero = dz_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      quo_q        <= '0;
      frac_q       <= '0;
    end else begin
      resp_valid_q <= tag_out.valid;
      if (tag_out.valid) begin
        resp_id_q <= tag_out.id[IdW-1:0];
        quo_q     <= bus.div_quotient;
        frac_q    <= bus.div_fractional;
      end
    end
  end

  assign bus.resp_divzero = 1'b0;
`endif

  always_comb begin
    busy_c = op_tag_q.valid | resp_valid_q;
    for (int unsigned i = 0; i < DIV_LAT; i++) busy_c = busy_c | pipe_q[i].valid;
  end

  assign bus.req_ready       = gnt;
  assign bus.div_dividend    = div_a_q;
  assign bus.div_divisor     = div_b_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_id         = resp_id_q;
  assign bus.resp_quotient   = quo_q;
  assign bus.resp_fractional = frac_q;
  assign bus.busy            = busy_c;

endmodule

// File: tb/tb_hsv_div_arbiter.sv
// Bench for hsv_div_arbiter: directed scenarios plus random traffic, with an
// operation-level model (grant rule, pending-response queue) checked every cycle.
module tb_hsv_div_arbiter;

  localparam int NREQ    = 3;
  localparam int W       = 12;
  localparam int DIV_LAT = 4;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   cyc;
  int   total;
  int   bad;

  hsv_div_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  hsv_div_arbiter #(
    .NREQ    (NREQ),
    .W       (W),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Divider core stand-in: integer quotient and W-bit binary fraction, all-ones on /0.
  function automatic logic [W-1:0] q_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [W-1:0] f_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    if (b == '0) return '1;
    r = (2*W)'(a % b) << W;
    return W'(r / (2*W)'(b));
  endfunction

  logic [W-1:0] dq [DIV_LAT];
  logic [W-1:0] df [DIV_LAT];

  always @(posedge clk) begin
    dq[0] <= q_ref(bus.div_dividend, bus.div_divisor);
    df[0] <= f_ref(bus.div_dividend, bus.div_divisor);
    for (int i = 1; i < DIV_LAT; i++) begin
      dq[i] <= dq[i-1];
      df[i] <= df[i-1];
    end
  end

  assign bus.div_quotient   = dq[DIV_LAT-1];
  assign bus.div_fractional = df[DIV_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: grant rule, expected operand register and a queue of pending responses.
  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] q;
    logic [W-1:0] f;
    logic         dz;
  } exp_t;

  exp_t         pend[$];
  int           last_g;
  logic [W-1:0] m_div_a;
  logic [W-1:0] m_div_b;

  task automatic model_step();
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    int              g;
    int              i;
    exp_t            e;
    if (!rst_n) begin
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      pend.delete();
      last_g  = NREQ - 1;
      m_div_a = '0;
      m_div_b = '0;
      return;
    end
    g       = -1;
    exp_rdy = '0;
    if (bus.ce) begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (last_g + k) % NREQ;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("busy", 32'(bus.busy), 32'(pend.size() != 0));
    check("div_dividend", 32'(bus.div_dividend), 32'(m_div_a));
    check("div_divisor", 32'(bus.div_divisor), 32'(m_div_b));
    if (pend.size() != 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      check("resp_valid", 32'(bus.resp_valid), 1);
      check("resp_id", 32'(bus.resp_id), e.id);
      check("resp_quotient", 32'(bus.resp_quotient), 32'(e.q));
      check("resp_fractional", 32'(bus.resp_fractional), 32'(e.f));
      check("resp_divzero", 32'(bus.resp_divzero), 32'(e.dz));
    end else begin
      check("resp_idle", 32'(bus.resp_valid), 0);
    end
    if (g >= 0) begin
      a     = bus.req_dividend[g*W +: W];
      b     = bus.req_divisor[g*W +: W];
      e.due = cyc + DIV_LAT + 2;
      e.id  = g;
      e.q   = q_ref(a, b);
      e.f   = f_ref(a, b);
      e.dz  = 1'b0;
`ifdef HSV_DIV_ARB_DIVZERO_EN
      if (b == '0) begin
        e.q  = '0;
        e.f  = '0;
        e.dz = 1'b1;
      end
`endif
      pend.push_back(e);
      last_g  = g;
      m_div_a = a;
      m_div_b = b;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_dividend[i*W +: W] = a;
    bus.req_divisor[i*W +: W]  = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_div_dividend"}, 32'(bus.div_dividend), 0);
    check({tag, "_div_divisor"}, 32'(bus.div_divisor), 0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
    check({tag, "_resp_id"}, 32'(bus.resp_id), 0);
    check({tag, "_resp_quotient"}, 32'(bus.resp_quotient), 0);
    check({tag, "_resp_fractional"}, 32'(bus.resp_fractional), 0);
    check({tag, "_resp_divzero"}, 32'(bus.resp_divzero), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  logic [NREQ-1:0] rr_seq [NREQ];

  initial begin
    total            = 0;
    bad              = 0;
    cyc              = 0;
    chk_en           = 1'b0;
    rst_n            = 1'b1;
    bus.ce           = 1'b0;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    rr_seq[0]        = 3'b001;
    rr_seq[1]        = 3'b010;
    rr_seq[2]        = 3'b100;
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    bus.req_valid = 3'b111;
    bus.ce        = 1'b1;
    #1;
    check_all_zero("reset");
    bus.req_valid = '0;
    rst_n         = 1'b1;
    repeat (3) step();

    // Single request: 0x300/0x600 -> q=0, frac=0x800, response DIV_LAT+2 later.
    set_req(0, 12'h300, 12'h600);
    bus.req_valid = 3'b001;
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = '0;
    for (int k = 1; k <= DIV_LAT + 3; k++) begin
      @(negedge clk);
      check("single_busy", 32'(bus.busy), 32'(k <= DIV_LAT + 2));
      check("single_resp_valid", 32'(bus.resp_valid), 32'(k == DIV_LAT + 2));
      if (k == DIV_LAT + 2) begin
        check("single_resp_id", 32'(bus.resp_id), 0);
        check("single_quotient", 32'(bus.resp_quotient), 0);
        check("single_fractional", 32'(bus.resp_fractional), 32'h800);
      end
    end
    step();

    // All requesters valid from reset: grants and responses rotate 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, W'(12'h111 * (i + 1)), W'(12'h040 + i));
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(bus.req_ready), 32'(rr_seq[k % NREQ]));
      step();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_resp_valid", 32'(bus.resp_valid), 1);
      check("rr_resp_id", 32'(bus.resp_id), k % NREQ);
      step();
    end
    repeat (2) step();

    // ce low blocks grants; first ce-high cycle grants.
    set_req(1, 12'h9ab, 12'h013);
    bus.ce        = 1'b0;
    bus.req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ce_low_ready", 32'(bus.req_ready), 0);
      step();
    end
    bus.ce = 1'b1;
    @(negedge clk);
    check("ce_high_ready", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = '0;
    for (int k = 1; k <= DIV_LAT + 2; k++) begin
      @(negedge clk);
      check("ce_resp_valid", 32'(bus.resp_valid), 32'(k == DIV_LAT + 2));
      if (k == DIV_LAT + 2) check("ce_resp_id", 32'(bus.resp_id), 1);
    end
    step();

    // Reset two cycles after accepting req2 discards it.
    set_req(2, 12'hfed, 12'h007);
    bus.req_valid = 3'b100;
    @(negedge clk);
    check("mid_grant", 32'(bus.req_ready), 32'b100);
    step();
    bus.req_valid = '0;
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_reset_quiet", 32'(bus.resp_valid), 0);
      step();
    end
    bus.req_valid = 3'b111;
    @(negedge clk);
    check("post_reset_grant", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = '0;
    repeat (DIV_LAT + 3) step();

    // Zero divisor.
    set_req(0, 12'h123, 12'h000);
    bus.req_valid = 3'b001;
    @(negedge clk);
    check("dz_ready", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = '0;
    for (int k = 1; k <= DIV_LAT + 2; k++) @(negedge clk);
    check("dz_resp_valid", 32'(bus.resp_valid), 1);
`ifdef HSV_DIV_ARB_DIVZERO_EN
    check("dz_flag", 32'(bus.resp_divzero), 1);
    check("dz_quotient", 32'(bus.resp_quotient), 0);
    check("dz_fractional", 32'(bus.resp_fractional), 0);
`else
    check("dz_flag", 32'(bus.resp_divzero), 0);
    check("dz_quotient", 32'(bus.resp_quotient), 32'hfff);
    check("dz_fractional", 32'(bus.resp_fractional), 32'hfff);
`endif
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.ce        = ($urandom % 8) != 0;
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, W'($urandom), (($urandom % 8) == 0) ? '0 : W'($urandom));
      end
      if (n == 200) rst_n = 1'b0;
      if (n == 202) rst_n = 1'b1;
      step();
    end
    bus.req_valid = '0;
    repeat (DIV_LAT + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsv_div_arbiter.md
HSV_DIV_ARBITER -- requirements
Module: hsv_div_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning the number of requesters sharing one divider.
REQ-002 The block SHALL have parameter W, default 12, meaning the dividend, divisor, quotient and fractional width.
REQ-003 The block SHALL have parameter DIV_LAT, default 4, meaning the fixed latency in cycles of the external divider core.
REQ-004 The block SHALL have the following ports.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ce  in  1  grant enable; no new grants while low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_dividend  in  NREQ*W  flattened dividends; requester i occupies bits [i*W +: W].
- req_divisor  in  NREQ*W  flattened divisors; same layout as req_dividend.
- div_dividend  out  W  registered operand driven to the divider.
- div_divisor  out  W  registered operand driven to the divider.
- div_quotient  in  W  divider result.
- div_fractional  in  W  divider result.
- resp_valid  out  1  response strobe.
- resp_id  out  clog2(NREQ)  index of the requester that owns the response.
- resp_quotient  out  W  registered quotient.
- resp_fractional  out  W  registered fractional.
- resp_divzero  out  1  divide-by-zero flag.
- busy  out  1  high when any operation is in flight.

Function
REQ-005 Arbitration SHALL be round-robin, with at most one grant per cycle.
REQ-006 The search SHALL start at (last_grant+1) mod NREQ.
REQ-007 The last_grant pointer SHALL reset to NREQ-1, so requester 0 has first priority.
REQ-008 req_ready[i] SHALL be combinational and SHALL be high only when ce=1, req_valid[i]=1 and i is the arbitration winner.
REQ-009 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high.
REQ-010 A requester SHALL hold req_valid and its operands stable until accepted; the block need not check this.
REQ-011 On a transfer in cycle T, the operands SHALL be registered onto div_dividend/div_divisor at T+1.
REQ-012 On a transfer in cycle T, a tag {valid, id, divzero} SHALL enter a DIV_LAT-deep shift register.
REQ-013 The tag SHALL emerge aligned with div_quotient/div_fractional at T+1+DIV_LAT.
REQ-014 The response (resp_valid, resp_id, resp_quotient, resp_fractional, resp_divzero) SHALL be registered and presented for exactly one cycle at T+2+DIV_LAT, giving a total latency of DIV_LAT+2.
REQ-015 The tag pipeline SHALL advance every cycle regardless of ce, because the divider cannot stall; ce=0 only suppresses new grants.
REQ-016 Responses SHALL have no backpressure; consumers SHALL accept resp_valid unconditionally.
REQ-017 With continuous requests, throughput SHALL be one operation per cycle.
REQ-018 With all NREQ requesters continuously valid, grants SHALL rotate 0,1,2,0,...
REQ-019 When no request is granted, div_dividend/div_divisor SHALL hold their previous value, and a tag with valid=0 SHALL be inserted.
REQ-020 busy SHALL equal the OR of the operand-stage valid, all tag valids and the response-stage valid.
REQ-021 Operations SHALL complete in acceptance order, with no reordering.
REQ-022 A request whose req_valid drops before grant SHALL be ignored, with no state change.

Reset
REQ-023 On rst_n low, all tag valids, resp_valid, busy, resp_id, resp_quotient, resp_fractional, resp_divzero, div_dividend and div_divisor SHALL clear to 0 immediately.
REQ-024 On rst_n low, last_grant SHALL be set to NREQ-1 immediately.
REQ-025 Reset mid-operation SHALL discard in-flight operations, and no resp_valid SHALL appear for them after release.
REQ-026 req_ready SHALL be 0 while rst_n is low.

Configuration
REQ-027 With macro HSV_DIV_ARB_DIVZERO_EN defined, a tag SHALL record divzero=1 when the granted divisor equals 0.
REQ-028 With HSV_DIV_ARB_DIVZERO_EN defined, a divzero response SHALL force resp_quotient=0 and resp_fractional=0 and set resp_divzero=1, so S=0 results when V=0.
REQ-029 Without HSV_DIV_ARB_DIVZERO_EN, resp_divzero SHALL be tied to 0, the tag SHALL have no divzero bit, and raw divider outputs SHALL be passed through.

Structure
REQ-030 The shared package hsv_pkg SHALL hold the NREQ/W/DIV_LAT defaults, the ID width function and the tag struct type {valid, id, divzero}.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (NREQ-wide request vector, enable input, one-hot grant, pointer update on grant).
REQ-032 The divider core SHALL be instantiated outside this block.

Verification
REQ-033 The bench SHALL cover a single request: req0 dividend=0x300, divisor=0x600 at cycle 10 -> req_ready[0]=1 at cycle 10; resp_valid at cycle 16 with id=0, quotient=0, fractional=0x800; busy high cycles 11-16.
REQ-034 The bench SHALL cover all three requesters held valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; six responses in the same order at consecutive cycles.
REQ-035 The bench SHALL cover req1 valid with ce=0 for 3 cycles, then ce=1 -> no req_ready while ce=0; grant in the first ce=1 cycle; response DIV_LAT+2 later.
REQ-036 The bench SHALL cover rst_n asserted 2 cycles after accepting req2 -> all outputs 0 immediately; no resp_valid for 20 cycles after release; next grant goes to req0.
REQ-037 The bench SHALL cover HSV_DIV_ARB_DIVZERO_EN defined with req0 divisor=0, dividend=0x123 -> resp_divzero=1, quotient=0, fractional=0.
REQ-038 The bench SHALL cover HSV_DIV_ARB_DIVZERO_EN undefined with the same divisor=0 stimulus -> resp_divzero=0 and divider output passed through unchanged.
